// File: rtl/conv_cfg_pkg.sv
// Register map and FSM state shared between the configuration master
// and the convolution controller's slave decode.
package conv_cfg_pkg;

   localparam int unsigned CTRL_OFS        = 0;
   localparam int unsigned RST_OFS         = 4;
   localparam int unsigned WIDTH_OFS       = 16;
   localparam int unsigned HEIGHT_OFS      = 20;
   localparam int unsigned FILTER_BASE_OFS = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WAIT_B,
      ST_DONE,
      ST_ERR
   } state_t;

   // Length of the register write list for a given kernel and soft-reset option.
   function automatic int unsigned num_writes(input int unsigned kernel_size,
                                              input bit          soft_reset_en);
      return 3 + kernel_size * kernel_size + (soft_reset_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/conv_cfg_master.sv
// AXI4-Lite write-only master: on start, snapshots the picture/filter
// configuration and writes the controller registers one transaction at a time.
module conv_cfg_master
   import conv_cfg_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned KERNEL_SIZE    = 3,
   parameter bit          SOFT_RESET_EN  = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                  axi_clk,
   input  logic                                  axi_reset_n,
   input  logic                                  start,
   input  logic [31:0]                           cfg_width,
   input  logic [31:0]                           cfg_height,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] cfg_filter,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [ADDR_WIDTH-1:0]                 m_axi_awaddr,
   output logic                                  m_axi_awvalid,
   input  logic                                  m_axi_awready,
   output logic [31:0]                           m_axi_wdata,
   output logic                                  m_axi_wvalid,
   input  logic                                  m_axi_wready,
   input  logic                                  m_axi_bvalid,
   output logic                                  m_axi_bready
);

   localparam int unsigned NUM_COEF   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned NUM_WRITES = num_writes(KERNEL_SIZE, SOFT_RESET_EN);
   localparam int unsigned IDX_W      = $clog2(NUM_WRITES);
   localparam int unsigned COEF_W     = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
   localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   // Without the soft reset the list starts at the CTRL entry.
   localparam int unsigned FIRST_POS  = SOFT_RESET_EN ? 0 : 1;

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    cnt;
   logic                aw_done;
   logic                w_done;

   logic [31:0]         width_q;
   logic [31:0]         height_q;
   logic [31:0]         filter_q [NUM_COEF];

   logic                aw_hs;
   logic                w_hs;
   logic                phase_done;
   logic                timeout;
   logic                last_write;
   int unsigned         pos;
   logic [COEF_W-1:0]   coef_sel;
   logic [31:0]         coef;
   logic [ADDR_WIDTH-1:0] entry_addr;
   logic [31:0]         entry_data;

   // List position -> {address, data}; positions 4 and up are filter taps.
   function automatic logic [ADDR_WIDTH+31:0] write_entry(input int unsigned pos_in,
                                                          input logic [31:0] w,
                                                          input logic [31:0] h,
                                                          input logic [31:0] c);
      logic [ADDR_WIDTH+31:0] e;
      case (pos_in)
         0:       e = {ADDR_WIDTH'(RST_OFS), 32'd1};
         1:       e = {ADDR_WIDTH'(CTRL_OFS), 32'd1};
         2:       e = {ADDR_WIDTH'(WIDTH_OFS), w};
         3:       e = {ADDR_WIDTH'(HEIGHT_OFS), h};
         default: e = {ADDR_WIDTH'(FILTER_BASE_OFS + 4 * (pos_in - 4)), c};
      endcase
      return e;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      coef_sel = '0;
      pos      = 32'(idx) + FIRST_POS;
      if (pos >= 32'd4) begin
         coef_sel = COEF_W'(pos - 32'd4);
      end
      coef = filter_q[coef_sel];
      {entry_addr, entry_data} = write_entry(pos, width_q, height_q, coef);
   end

   assign m_axi_awvalid = (state == ST_WRITE) && !aw_done;
   assign m_axi_wvalid  = (state == ST_WRITE) && !w_done;
   assign m_axi_bready  = (state == ST_WAIT_B);
   assign m_axi_awaddr  = m_axi_awvalid ? entry_addr : '0;
   assign m_axi_wdata   = m_axi_wvalid  ? entry_data : '0;

   assign busy  = (state == ST_WRITE) || (state == ST_WAIT_B);
   assign done  = (state == ST_DONE);
   assign error = (state == ST_ERR);

   assign aw_hs      = m_axi_awvalid && m_axi_awready;
   assign w_hs       = m_axi_wvalid && m_axi_wready;
   assign phase_done = (aw_done || aw_hs) && (w_done || w_hs);
   assign timeout    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign last_write = (idx == IDX_W'(NUM_WRITES - 1));

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (phase_done)   state_next = ST_WAIT_B;
            else if (timeout) state_next = ST_ERR;
         end
         ST_WAIT_B: begin
            if (m_axi_bvalid) state_next = last_write ? ST_DONE : ST_WRITE;
            else if (timeout) state_next = ST_ERR;
         end
         ST_DONE: state_next = ST_IDLE;
         ST_ERR:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         cnt     <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_next;

         if (state == ST_IDLE && start) begin
            idx <= '0;
         end else if (state == ST_WAIT_B && m_axi_bvalid && !last_write) begin
            idx <= idx + IDX_W'(1);
         end

         // Any state change restarts the per-phase timeout window.
         if (state_next != state) begin
            cnt <= '0;
         end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
         end

         // Phase-complete flags live only within one WRITE visit.
         if (state == ST_WRITE && state_next == ST_WRITE) begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done || w_hs;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
      end
   end

   // NOTE: the snapshot is pure datapath, always loaded before it is read, so it carries no reset.
   always_ff @(posedge axi_clk) begin
      if (state == ST_IDLE && start) begin
         width_q  <= cfg_width;
         height_q <= cfg_height;
         for (int i = 0; i < NUM_COEF; i++) begin
            filter_q[i] <= cfg_filter[i*32 +: 32];
         end
      end
   end

endmodule

// File: tb/tb_conv_cfg_master.sv
// Directed bench for conv_cfg_master: a configurable AXI-Lite slave plus a
// negedge monitor logging every handshake, checked against hand-computed lists.
module tb_conv_cfg_master;

   localparam int AW = 10;
   localparam int KK = 9;
   localparam int N  = 13;
   localparam int TO = 16;

   logic              axi_clk     = 1'b0;
   logic              axi_reset_n = 1'b0;
   logic              start       = 1'b0;
   logic [31:0]       cfg_width   = '0;
   logic [31:0]       cfg_height  = '0;
   logic [KK*32-1:0]  cfg_filter  = '0;
   logic              busy, done, error;
   logic [AW-1:0]     m_axi_awaddr;
   logic              m_axi_awvalid;
   logic              m_axi_awready;
   logic [31:0]       m_axi_wdata;
   logic              m_axi_wvalid;
   logic              m_axi_wready;
   logic              m_axi_bvalid;
   logic              m_axi_bready;

   conv_cfg_master #(
      .ADDR_WIDTH(AW), .KERNEL_SIZE(3), .SOFT_RESET_EN(1'b1), .TIMEOUT_CYCLES(TO)
   ) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_filter(cfg_filter),
      .busy(busy), .done(done), .error(error),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   always #5 axi_clk = ~axi_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Cycle counter: value k during the cycle following the k-th rising edge.
   int cyc = 0;
   initial forever begin
      @(posedge axi_clk);
      cyc++;
   end

   // Slave behaviour knobs and monitor logs.
   int          aw_delay = 0;
   bit          b_en     = 1'b1;
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   int          aw_len_q[$];
   int          w_len_q[$];
   int          aw_rise_q[$];
   int          b_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   int          busy_hi = 0, addr_unstable = 0, data_unstable = 0, early_b = 0;
   int          aw_run = 0, w_run = 0;
   logic [AW-1:0] prev_addr = '0;
   logic [31:0] prev_data = '0;
   logic        prev_aw = 1'b0, prev_w = 1'b0;

   initial begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      forever begin
         @(negedge axi_clk);
         if (m_axi_awvalid) begin
            if (!prev_aw) aw_rise_q.push_back(cyc);
            else if (m_axi_awaddr != prev_addr) addr_unstable++;
            m_axi_awready = (aw_run >= aw_delay);
            aw_run++;
            if (m_axi_awready) begin
               log_addr.push_back(32'(m_axi_awaddr));
               aw_len_q.push_back(aw_run);
            end
         end else begin
            aw_run        = 0;
            m_axi_awready = 1'b0;
         end
         if (m_axi_wvalid) begin
            if (prev_w && m_axi_wdata != prev_data) data_unstable++;
            m_axi_wready = 1'b1;
            w_run++;
            log_data.push_back(m_axi_wdata);
            w_len_q.push_back(w_run);
         end else begin
            w_run        = 0;
            m_axi_wready = 1'b0;
         end
         m_axi_bvalid = m_axi_bready && b_en;
         if (m_axi_bvalid) b_cnt++;
         if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) early_b++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (error) begin err_cnt++; err_cyc = cyc; end
         if (busy) busy_hi++;
         prev_aw   = m_axi_awvalid;
         prev_w    = m_axi_wvalid;
         prev_addr = m_axi_awaddr;
         prev_data = m_axi_wdata;
      end
   end

   logic [31:0] exp_addr [N];
   logic [31:0] exp_data [N];
   int ba, bw, brise, bb, bd, be, bbusy, bun, bdun, beb, s_cyc;

   task automatic step(input int n);
      repeat (n) @(negedge axi_clk);
      #1;
   endtask

   task automatic snap();
      ba = log_addr.size(); bw = log_data.size(); brise = aw_rise_q.size();
      bb = b_cnt; bd = done_cnt; be = err_cnt; bbusy = busy_hi;
      bun = addr_unstable; bdun = data_unstable; beb = early_b;
   endtask

   task automatic start_seq();
      step(1);
      start = 1'b1;
      s_cyc = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         step(1);
         if (done_cnt > bd || err_cnt > be) ok = 1'b1;
      end
      check({tag, "_end_reached"}, 32'(ok), 32'd1);
   endtask

   task automatic check_run(input string tag, input int lat, input int busy_cycles);
      check({tag, "_n_aw"}, log_addr.size() - ba, N);
      check({tag, "_n_w"}, log_data.size() - bw, N);
      check({tag, "_n_b"}, b_cnt - bb, N);
      check({tag, "_done_cnt"}, done_cnt - bd, 1);
      check({tag, "_err_cnt"}, err_cnt - be, 0);
      check({tag, "_done_lat"}, done_cyc - s_cyc, lat);
      check({tag, "_busy_cycles"}, busy_hi - bbusy, busy_cycles);
      for (int i = 0; i < N; i++) begin
         if (ba + i < log_addr.size()) check($sformatf("%s_addr%0d", tag, i), log_addr[ba+i], exp_addr[i]);
         if (bw + i < log_data.size()) check($sformatf("%s_data%0d", tag, i), log_data[bw+i], exp_data[i]);
      end
   endtask

   task automatic cfg_ideal();
      cfg_width  = 32'd8;
      cfg_height = 32'd8;
      cfg_filter = '0;
      cfg_filter[8*32 +: 32] = 32'd1;
      exp_data = '{32'd1, 32'd1, 32'd8, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
   endtask

   initial begin
      exp_addr = '{32'd4, 32'd0, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36,
                   32'd40, 32'd44, 32'd48, 32'd52, 32'd56};

      // Reset state
      step(3);
      check("rst_ctrl_outs", 32'({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
      check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
      check("rst_wdata", m_axi_wdata, 32'd0);
      axi_reset_n = 1'b1;
      step(2);

      // 1: ideal slave
      cfg_ideal();
      snap();
      start_seq();
      wait_end("t1");
      step(3);
      check_run("t1", 27, 26);
      if (brise < aw_rise_q.size()) check("t1_first_aw", aw_rise_q[brise] - s_cyc, 1);
      else check("t1_first_aw_seen", 32'd0, 32'd1);

      // 2: awready held off 3 cycles, distinct coefficients
      cfg_width  = 32'd640;
      cfg_height = 32'd480;
      for (int i = 0; i < KK; i++) cfg_filter[i*32 +: 32] = 32'(100 + i);
      exp_data = '{32'd1, 32'd1, 32'd640, 32'd480, 32'd100, 32'd101, 32'd102, 32'd103,
                   32'd104, 32'd105, 32'd106, 32'd107, 32'd108};
      aw_delay = 3;
      snap();
      start_seq();
      wait_end("t2");
      step(3);
      check_run("t2", 66, 65);
      if (ba < aw_len_q.size()) check("t2_aw_hold", aw_len_q[ba], 4);
      if (bw < w_len_q.size()) check("t2_w_hold", w_len_q[bw], 1);
      check("t2_addr_stable", addr_unstable - bun, 0);
      check("t2_data_stable", data_unstable - bdun, 0);
      check("t2_no_early_b", early_b - beb, 0);
      aw_delay = 0;

      // 3: snapshot and ignored start
      cfg_ideal();
      snap();
      start_seq();
      step(8);
      cfg_width = 32'd99;
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_end("t3");
      step(5);
      check_run("t3", 27, 26);
      check("t3_idle_busy", 32'(busy), 32'd0);

      // 4: write response never arrives
      cfg_ideal();
      b_en = 1'b0;
      snap();
      start_seq();
      wait_end("t4");
      check("t4_err_cnt", err_cnt - be, 1);
      check("t4_done_cnt", done_cnt - bd, 0);
      check("t4_err_lat", err_cyc - s_cyc, 18);
      check("t4_n_aw", log_addr.size() - ba, 1);
      step(1);
      check("t4_bready_after", 32'(m_axi_bready), 32'd0);
      check("t4_busy_after", 32'(busy), 32'd0);
      b_en = 1'b1;
      snap();
      start_seq();
      wait_end("t4r");
      step(3);
      check_run("t4r", 27, 26);

      // 5: reset during write index 5
      cfg_ideal();
      snap();
      start_seq();
      step(10);
      check("t5_idx5_addr", 32'(m_axi_awaddr), 32'd28);
      axi_reset_n = 1'b0;
      step(1);
      check("t5_rst_outs", 32'({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
      step(2);
      axi_reset_n = 1'b1;
      step(2);
      check("t5_no_done", done_cnt - bd, 0);
      check("t5_no_err", err_cnt - be, 0);
      snap();
      start_seq();
      wait_end("t5r");
      step(3);
      check_run("t5r", 27, 26);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
